mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one mem_system instance (unified cache + four-bank memory) between an instruction-fetch
//   requester (read-only) and a data requester (read/write). Selects a requester, holds the address
//   and write data stable for the whole transaction, and pulses Rd/Wr for one cycle. Returns the
//   response to the owner, counts cache hits per requester and runs a hang watchdog.
// PARAMETERS
//   ARB_MODE  0   0 = round-robin, 1 = data requester has fixed priority
//   TIMEOUT   63  max cycles in WAIT before watchdog fires (6-bit counter, 1..63)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   i_req      in   1   fetch request (level)
//   i_addr     in   16  fetch address
//   i_gnt      out  1   fetch request accepted this cycle (operands captured)
//   i_done     out  1   fetch response valid (1-cycle pulse)
//   i_rdata    out  16  fetch read data, valid with i_done
//   d_req      in   1   data request (level)
//   d_wr       in   1   1 = write, 0 = read
//   d_addr     in   16  data address
//   d_wdata    in   16  data write value
//   d_gnt      out  1   data request accepted this cycle
//   d_done     out  1   data response valid (1-cycle pulse)
//   d_rdata    out  16  data read data, valid with d_done (0 for writes)
//   m_addr     out  16  to mem_system Addr
//   m_din      out  16  to mem_system DataIn
//   m_rd       out  1   to mem_system Rd
//   m_wr       out  1   to mem_system Wr
//   m_dout     in   16  from mem_system DataOut
//   m_done     in   1   from mem_system Done
//   m_stall    in   1   from mem_system Stall (0 only when it is idle)
//   m_hit      in   1   from mem_system CacheHit
//   m_err      in   1   from mem_system err
//   i_hit_cnt  out  16  fetch cache-hit count, saturating at 16'hFFFF
//   d_hit_cnt  out  16  data cache-hit count, saturating at 16'hFFFF
//   err        out  1   sticky: watchdog fired OR m_err seen
// BEHAVIOUR
//   Reset: FSM=IDLE, owner=I, rr_last=I, all outputs/registers 0.
//   Reset mid-transaction aborts it with no done pulse; mem_system is reset by its own reset.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if (i_req|d_req) & !m_stall, pick a winner and pulse its *_gnt. Capture addr, wdata,
//     wr (fetch: wr=0) and owner into registers; go to ISSUE. Otherwise stay in IDLE.
//   Arbitration, both requesting: ARB_MODE=1 -> D wins. ARB_MODE=0 -> the one not equal to
//     rr_last wins. rr_last is updated on every grant. A single requester always wins.
//   ISSUE (1 cycle): m_rd = !wr_q, m_wr = wr_q, exactly one cycle. Clear watchdog counter. Go to WAIT.
//   m_addr/m_din driven from captured registers in ISSUE and WAIT; 0 in IDLE and RESP.
//   WAIT: watchdog counter increments each cycle. On m_done: latch rdata_q = wr_q ? 0 : m_dout.
//     If m_hit, increment the owner's hit counter (saturating). Go to RESP.
//     If the counter reaches TIMEOUT before m_done: set err, rdata_q=0, go to RESP.
//   RESP (1 cycle): owner's *_done=1 and *_rdata=rdata_q; the other requester sees done=0 and rdata=0.
//     req inputs are ignored in RESP. Go to IDLE.
//   Handshake: requester holds req until its done. Operands are sampled only at gnt, so later
//     changes are ignored. Dropping req after gnt does not abort the transaction.
//     req still high in the cycle after done = new request.
//   Latency, cache hit: gnt at cycle T, m_rd at T+1, m_done at T+2, done at T+3.
//     Back-to-back: next gnt at T+4 at the earliest.
//   Miss: done is issued 1 cycle after m_done, however long mem_system takes.
//   err: set by watchdog or by m_err=1 in any state. Cleared only by reset. err does not block
//     further arbitration.
//   A second m_done outside WAIT is ignored.
// TESTING
//   1 i_req=1, i_addr=16'h0040, cache hit -> i_gnt@T, m_rd pulse@T+1, i_done@T+3, i_rdata=m_dout, i_hit_cnt=1.
//   2 i_req,d_req both held high, ARB_MODE=0, hits -> grants alternate D,I,D,I; each done only to its owner.
//   3 Same as 2 with ARB_MODE=1, d_req held high 4 txns -> i_gnt never asserts until d_req drops.
//   4 d_wr=1, d_addr=16'h1238, d_wdata=16'hBEEF, dirty miss -> m_addr/m_din stable until m_done,
//     d_done 1 cycle later, d_rdata=0, d_hit_cnt unchanged.
//   5 m_done held 0 after issue, TIMEOUT=63 -> RESP 63 cycles after ISSUE, rdata=0, err=1,
//     err stays 1 until rst_n low.
//   6 rst_n low for 1 cycle during WAIT -> all outputs 0 immediately, no done pulse;
//     a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and mem_system signals around the arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [15:0] d_rdata;
  logic [15:0] m_addr;
  logic [15:0] m_din;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_dout;
  logic        m_done;
  logic        m_stall;
  logic        m_hit;
  logic        m_err;
  logic [15:0] i_hit_cnt;
  logic [15:0] d_hit_cnt;
  logic        err;
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  m_dout, m_done, m_stall, m_hit, m_err,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    output m_addr, m_din, m_rd, m_wr, i_hit_cnt, d_hit_cnt, err
  );
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output m_dout, m_done, m_stall, m_hit, m_err,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    input  m_addr, m_din, m_rd, m_wr, i_hit_cnt, d_hit_cnt, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between a fetch and a data requester
module mem_arbiter #(
  parameter bit          ARB_MODE = 1'b0,
  parameter int unsigned TIMEOUT  = 63
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state, state_nxt;
  logic        owner_q;
  logic        rr_last;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [5:0]  wd_cnt;
  logic [15:0] i_hit_q;
  logic [15:0] d_hit_q;
  logic        err_q;
  logic        go;
  logic        pick_d;
  logic        timeout;
  logic        busy;
  logic        resp;
  logic        finish;
  // arbitration and next state; owner/rr_last encode 0 = fetch, 1 = data
  always_comb begin
    go        = (state == IDLE) && (bus.i_req || bus.d_req) && !bus.m_stall;
    pick_d    = bus.d_req && (!bus.i_req || ARB_MODE || !rr_last);
    timeout   = ({1'b0, wd_cnt} + 7'd2) >= 7'(TIMEOUT);
    finish    = (state == WAIT) && (bus.m_done || timeout);
    state_nxt = state == IDLE  ? (go ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? (finish ? RESP : WAIT) : IDLE;
  end
  assign busy          = (state == ISSUE) || (state == WAIT);
  assign resp          = state == RESP;
  assign bus.i_gnt     = go && !pick_d;
  assign bus.d_gnt     = go && pick_d;
  assign bus.m_rd      = (state == ISSUE) && !wr_q;
  assign bus.m_wr      = (state == ISSUE) && wr_q;
  assign bus.m_addr    = busy ? addr_q : 16'h0000;
  assign bus.m_din     = busy ? wdata_q : 16'h0000;
  assign bus.i_done    = resp && !owner_q;
  assign bus.d_done    = resp && owner_q;
  assign bus.i_rdata   = bus.i_done ? rdata_q : 16'h0000;
  assign bus.d_rdata   = bus.d_done ? rdata_q : 16'h0000;
  assign bus.i_hit_cnt = i_hit_q;
  assign bus.d_hit_cnt = d_hit_q;
  assign bus.err       = err_q;
  // transaction state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  // operands are sampled only at grant so requesters may change them afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      rr_last <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else if (go) begin
      owner_q <= pick_d;
      rr_last <= pick_d;
      wr_q    <= pick_d && bus.d_wr;
      addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
      wdata_q <= pick_d ? bus.d_wdata : 16'h0000;
    end
  end
  // watchdog counts WAIT cycles so RESP lands TIMEOUT cycles after ISSUE at the latest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= 6'd0;
      rdata_q <= 16'h0000;
    end else begin
      if (state == ISSUE)     wd_cnt <= 6'd0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 6'd1;
      if (finish) rdata_q <= (bus.m_done && !wr_q) ? bus.m_dout : 16'h0000;
    end
  end
  // saturating per-requester hit counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_hit_q <= 16'h0000;
      d_hit_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      if (state == WAIT && bus.m_done && bus.m_hit && !owner_q && i_hit_q != 16'hFFFF) i_hit_q <= i_hit_q + 16'd1;
      if (state == WAIT && bus.m_done && bus.m_hit && owner_q && d_hit_q != 16'hFFFF) d_hit_q <= d_hit_q + 16'd1;
      if (bus.m_err || (state == WAIT && !bus.m_done && timeout)) err_q <= 1'b1;
    end
  end
endmodule
